// File: rtl/c_wf_alloc_req_ctrl.sv
// Requester-side controller for a square wavefront allocator.
//
// Each input port holds at most one pending request (a multi-hot set of acceptable outputs).
// Held requests are driven onto a per-priority request matrix. The priority level rises with
// the request's age. The combined grant matrix is decoded to release served requests in the
// cycle they are granted. A new request may be loaded on the same edge that releases the old
// one, so a port can stay occupied back to back.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   active       clock enable; when low, state holds and served/update are forced to 0
//   in_valid     per-input new-request strobe
//   in_dest      per-input destination sets, row i = bits [i*P +: P]
//   in_ready     per-input accept; a request loads when in_valid & in_ready
//   req_pr       request matrix, bit index pr*P*P + i*P + j (level 0 is the highest)
//   gnt          combined grant matrix, row i = input, column j = output
//   update       allocator priority update, high when anything is served
//   served       per-input served strobe
//   served_port  per-input one-hot granted output (grant masked by held requests)
//   error        sticky protocol error flag
module c_wf_alloc_req_ctrl #(
  parameter int unsigned num_ports      = 8,
  parameter int unsigned num_priorities = 2,
  parameter int unsigned age_step       = 4,
  parameter int unsigned age_width      = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          active,
  input  logic [num_ports-1:0]                          in_valid,
  input  logic [num_ports*num_ports-1:0]                in_dest,
  output logic [num_ports-1:0]                          in_ready,
  output logic [num_priorities*num_ports*num_ports-1:0] req_pr,
  input  logic [num_ports*num_ports-1:0]                gnt,
  output logic                                          update,
  output logic [num_ports-1:0]                          served,
  output logic [num_ports*num_ports-1:0]                served_port,
  output logic                                          error
);

  localparam int unsigned P     = num_ports;
  localparam int unsigned MaxSt = num_priorities - 1;

  logic [P-1:0]         hold_valid_q, hold_valid_d;
  logic [P*P-1:0]       hold_dest_q, hold_dest_d;
  logic [age_width-1:0] age_q [P];
  logic [age_width-1:0] age_d [P];
  logic                 error_q, error_d;
  logic                 err_now;

  // Request matrix: a pure function of held state, independent of gnt.
  always_comb begin
    int unsigned stage;
    int unsigned lvl;
    req_pr = '0;
    for (int unsigned i = 0; i < P; i++) begin
      stage = 32'(age_q[i]) / age_step;
      if (stage > MaxSt) stage = MaxSt;
      lvl = MaxSt - stage;
      if (hold_valid_q[i]) begin
        req_pr[lvl*P*P + i*P +: P] = hold_dest_q[i*P +: P];
      end
    end
  end

  // Serve decode: only grant bits that land on a held request count.
  always_comb begin
    served_port = '0;
    served      = '0;
    for (int unsigned i = 0; i < P; i++) begin
      for (int unsigned j = 0; j < P; j++) begin
        served_port[i*P+j] = gnt[i*P+j] & hold_valid_q[i] & hold_dest_q[i*P+j] & active;
      end
      served[i] = |served_port[i*P +: P];
    end
  end

  assign update   = |served;
  assign in_ready = ~hold_valid_q | served;

  // Protocol checks: stray grants, multi-hot rows/columns, empty destination sets.
  always_comb begin
    logic hit;
    err_now = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      hit = 1'b0;
      for (int unsigned j = 0; j < P; j++) begin
        if (gnt[i*P+j]) begin
          if (hit) err_now = 1'b1;
          if (!(hold_valid_q[i] && hold_dest_q[i*P+j])) err_now = 1'b1;
          hit = 1'b1;
        end
      end
      if (in_valid[i] && in_ready[i] && (in_dest[i*P +: P] == '0)) err_now = 1'b1;
    end
    for (int unsigned j = 0; j < P; j++) begin
      hit = 1'b0;
      for (int unsigned i = 0; i < P; i++) begin
        if (gnt[i*P+j]) begin
          if (hit) err_now = 1'b1;
          hit = 1'b1;
        end
      end
    end
  end

  assign error_d = error_q | (active & err_now);

  // Next-state: load has precedence over release so bypass keeps the port occupied.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_dest_d  = hold_dest_q;
    for (int unsigned i = 0; i < P; i++) begin
      age_d[i] = age_q[i];
    end
    if (active) begin
      for (int unsigned i = 0; i < P; i++) begin
        if (in_valid[i] && in_ready[i] && (in_dest[i*P +: P] != '0)) begin
          hold_valid_d[i]        = 1'b1;
          hold_dest_d[i*P +: P] = in_dest[i*P +: P];
          age_d[i]               = '0;
        end else if (served[i]) begin
          hold_valid_d[i] = 1'b0;
          age_d[i]        = '0;
        end else if (hold_valid_q[i]) begin
          if (age_q[i] != {age_width{1'b1}}) age_d[i] = age_q[i] + 1'b1;
        end else begin
          age_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      hold_dest_q  <= '0;
      error_q      <= 1'b0;
      for (int unsigned i = 0; i < P; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_dest_q  <= hold_dest_d;
      error_q      <= error_d;
      for (int unsigned i = 0; i < P; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign error = error_q;

endmodule
